// File: rtl/sc_if.sv
// Handshake bundle for the sc counter: enable in, count and status out.
interface sc_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [WIDTH-1:0] r_reg;
  logic             max_tick;
  logic             wrap;

  modport master (output en, input r_reg, max_tick, wrap);
  modport slave  (input en, output r_reg, max_tick, wrap);
endinterface

// File: rtl/sc.sv
// Enable-gated modulus up-counter with terminal-count and one-cycle wrap status.
module sc #(
  parameter int              WIDTH = 4,
  parameter longint unsigned MOD   = 16,
  parameter longint unsigned INIT  = 0
) (
  input  logic clk,
  input  logic reset,
  sc_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > 32 || MOD < 2 || MOD > (64'd1 << WIDTH) || INIT >= MOD) begin : g_cfg_err
    $error("sc: illegal configuration WIDTH=%0d MOD=%0d INIT=%0d", WIDTH, MOD, INIT);
  end

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 64'd1);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   count_inc;
  logic             at_max;

  assign at_max    = (count_q == MAX_VAL);
  assign count_inc = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};

  // The carry out only fires from all-ones, which is the terminal count when MOD = 2^WIDTH.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.en) begin
      if (at_max || count_inc[WIDTH]) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_inc[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= INIT_VAL;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.r_reg    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.max_tick = at_max;

endmodule

// File: tb/tb_sc.sv
// Directed self-checking bench for sc: default 4-bit/mod-16 instance and a mod-10 instance.
module tb_sc;

  logic clk;
  logic reset_a;
  logic reset_b;
  int   test_count;
  int   fail_count;
  int   exp_b;
  logic exp_wrap_b;

  sc_if #(.WIDTH(4)) bus_a ();
  sc_if #(.WIDTH(4)) bus_b ();

  sc #(.WIDTH(4), .MOD(16), .INIT(0)) u_dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  sc #(.WIDTH(4), .MOD(10), .INIT(0)) u_dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge, one rising edge later.
  task automatic applyStimulus(input logic en_val);
    bus_a.en = en_val;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_count = 0;
    fail_count = 0;
    reset_a    = 1'b0;
    reset_b    = 1'b0;
    bus_a.en   = 1'b0;
    bus_b.en   = 1'b0;

    #20;
    checkOutput("rst_count", bus_a.r_reg, 4'h0);
    checkOutput("rst_wrap", bus_a.wrap, 1'b0);
    checkOutput("rst_max_tick", bus_a.max_tick, 1'b0);

    reset_a = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1);
      checkOutput("count_up", bus_a.r_reg, i);
    end

    applyStimulus(1'b0);
    checkOutput("hold_1", bus_a.r_reg, 4'h5);
    applyStimulus(1'b0);
    checkOutput("hold_2", bus_a.r_reg, 4'h5);
    checkOutput("hold_wrap", bus_a.wrap, 1'b0);
    applyStimulus(1'b1);
    checkOutput("resume", bus_a.r_reg, 4'h6);

    for (int i = 7; i <= 15; i++) begin
      applyStimulus(1'b1);
      checkOutput("count_to_max", bus_a.r_reg, i);
    end
    checkOutput("max_tick_at_f", bus_a.max_tick, 1'b1);
    checkOutput("no_wrap_at_f", bus_a.wrap, 1'b0);

    applyStimulus(1'b1);
    checkOutput("wrap_count", bus_a.r_reg, 4'h0);
    checkOutput("wrap_pulse", bus_a.wrap, 1'b1);
    checkOutput("wrap_max_tick", bus_a.max_tick, 1'b0);
    applyStimulus(1'b1);
    checkOutput("post_wrap_count", bus_a.r_reg, 4'h1);
    checkOutput("post_wrap_clear", bus_a.wrap, 1'b0);

    // Reset asserted halfway between edges while counting.
    bus_a.en = 1'b1;
    #5 reset_a = 1'b0;
    #1;
    checkOutput("mid_rst_count", bus_a.r_reg, 4'h0);
    checkOutput("mid_rst_wrap", bus_a.wrap, 1'b0);
    @(negedge clk);
    checkOutput("mid_rst_held", bus_a.r_reg, 4'h0);
    reset_a = 1'b1;
    applyStimulus(1'b1);
    checkOutput("first_edge_after_rst", bus_a.r_reg, 4'h1);

    for (int i = 2; i <= 15; i++) begin
      applyStimulus(1'b1);
    end
    checkOutput("race_setup", bus_a.r_reg, 4'hF);

    // Reset lands on the same instant as the rising edge that would wrap.
    bus_a.en = 1'b1;
    #10 reset_a = 1'b0;
    #1;
    checkOutput("race_count", bus_a.r_reg, 4'h0);
    checkOutput("race_wrap", bus_a.wrap, 1'b0);
    checkOutput("race_max_tick", bus_a.max_tick, 1'b0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ignores_clk", bus_a.r_reg, 4'h0);
    checkOutput("rst_ignores_clk_wrap", bus_a.wrap, 1'b0);
    reset_a  = 1'b1;
    bus_a.en = 1'b0;

    reset_b = 1'b1;
    checkOutput("mod10_start", bus_b.r_reg, 4'h0);
    exp_b = 0;
    for (int i = 0; i < 30; i++) begin
      bus_b.en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_wrap_b = (exp_b == 9);
      exp_b      = (exp_b == 9) ? 0 : exp_b + 1;
      checkOutput("mod10_count", bus_b.r_reg, exp_b);
      checkOutput("mod10_wrap", bus_b.wrap, exp_wrap_b);
      checkOutput("mod10_max_tick", bus_b.max_tick, (exp_b == 9));
    end
    bus_b.en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/sc.md
Name: sc

Overview:
- Free-running, enable-gated binary up-counter with modulus wrap and terminal-count status.
- Used as a generic event/cycle counter in sequential datapaths.
- Default configuration is a 4-bit counter, modulus 16.
- Counter state is the directly exposed register r_reg.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..32.
- MOD, 16, counter modulus; count runs 0..MOD-1. Legal range 2..2^WIDTH. Values outside this range are a configuration error (simulation $error at time 0).
- INIT, 0, reset/load value of r_reg; must be < MOD.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
- en  input  1  count enable, sampled on rising clk.
- r_reg  output  WIDTH  current count value (registered).
- max_tick  output  1  combinational; 1 when r_reg == MOD-1.
- wrap  output  1  registered; 1 for exactly one cycle after a cycle in which r_reg wrapped MOD-1 -> 0.

Behaviour:
- Reset:
  - reset=0 asynchronously sets r_reg=INIT and wrap=0, independent of clk and en.
  - max_tick follows r_reg.
  - While reset=0, all clock edges are ignored.
- Deassertion: the first rising clk with reset=1 may count; no extra synchronisation stage inside the block.
- Counting, at each rising clk with reset=1:
  - en=1 and r_reg<MOD-1: r_reg <= r_reg+1, wrap <= 0.
  - en=1 and r_reg==MOD-1: r_reg <= 0, wrap <= 1.
  - en=0: r_reg holds; wrap <= 0.
- Latency: one clock from en sampled high to the r_reg increment being visible.
- Wrap-around:
  - With MOD=2^WIDTH, wrap is the natural overflow (e.g. 4'b1111 -> 4'b0000).
  - With MOD<2^WIDTH, values >= MOD are never reached.
- Width rule: increment computed in WIDTH+1 bits; the compare to MOD-1 uses full width; no truncation warnings.
- Mid-operation reset: reset asserting at any point (including coincident with a clk edge, or during a wrap cycle) wins. r_reg=INIT and wrap=0 take effect immediately.
- en changing at reset deassertion: en is sampled only at clk edges where reset=1.
- No X-propagation from en: en=X with reset=1 is illegal input; the design need not handle it. r_reg never goes X after reset.
- All outputs are driven at all times; no latches; a single always block for state, separate combinational logic for max_tick.

Test Plan:
- Reset: clk period 20 ns; reset=0, en=0 for 20 ns -> r_reg=0000, wrap=0, max_tick=0. Assert reset=0 mid-cycle (not on an edge) while counting -> r_reg=0000 before the next clk edge.
- Enable count: reset=1, en=1 for 5 edges from 0 -> r_reg steps 0001, 0010, 0011, 0100, 0101, one step per rising edge.
- Hold: en=0 for 2 edges at r_reg=0101 -> r_reg stays 0101; en=1 again -> next edge gives 0110.
- Wrap, default parameters: count up to 1111 -> max_tick=1. The next enabled edge gives r_reg=0000 and wrap=1 for one cycle. The following edge gives wrap=0.
- Modulus: MOD=10, WIDTH=4 -> sequence 0..9. At 1001, max_tick=1; the next edge gives 0000 with wrap pulse. 1010 never appears over 30 enabled edges.
- Reset vs. edge race: reset=0 coincident with a rising clk while en=1 and r_reg=1111 -> r_reg=INIT (0000), wrap=0. No wrap pulse is ever emitted for that edge.
